// File: rtl/vga_sync_analyzer_if.sv
// Sync link between a VGA timing source and the sync analyzer.
// The master drives hsync/vsync; the slave returns the recovered timing.
interface vga_sync_analyzer_if;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        display_on;
    logic        locked;
    logic        timing_err;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;

    modport master (
        output hsync_in, vsync_in,
        input  hpos, vpos, display_on, locked, timing_err, line_len, frame_lines
    );

    modport slave (
        input  hsync_in, vsync_in,
        output hpos, vpos, display_on, locked, timing_err, line_len, frame_lines
    );
endinterface

// File: rtl/vga_sync_analyzer.sv
// Receive side of the VGA timing link: measures incoming sync, regenerates
// hpos/vpos/display_on and qualifies the timing with a SEARCH/VERIFY/LOCKED FSM.
module vga_sync_analyzer #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_MAX       = 799,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_MAX       = 524,
    parameter int unsigned H_EDGE_POS  = 658,
    parameter int unsigned V_EDGE_POS  = 491,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input logic                clk,
    input logic                reset,
    vga_sync_analyzer_if.slave link
);
    localparam logic [10:0] LINE_CLKS    = 11'(H_MAX + 1);
    localparam logic [10:0] TIMEOUT_CLKS = 11'(2 * (H_MAX + 1));
    localparam logic [9:0]  FRAME_LEN    = 10'(V_MAX + 1);
    localparam logic [9:0]  H_LAST       = 10'(H_MAX);
    localparam logic [9:0]  V_LAST       = 10'(V_MAX);
    localparam logic [9:0]  H_VIS        = 10'(H_DISPLAY);
    localparam logic [9:0]  V_VIS        = 10'(V_DISPLAY);
    localparam logic [9:0]  H_LOAD       = 10'(H_EDGE_POS);
    localparam logic [9:0]  V_LOAD       = 10'(V_EDGE_POS);
    localparam logic [7:0]  LOCK_N       = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t      state, state_next;
    logic [7:0]  good_cnt, good_next;
    logic        err_next;

    logic        hsync_q, vsync_q;
    logic        h_edge, v_edge;
    logic [10:0] hcnt;
    logic        hsync_seen;
    logic        line_bad;
    logic [9:0]  line_cnt;
    logic        v_pend;
    logic [9:0]  hpos_r, vpos_r;
    logic        timing_err_r;
    logic [10:0] line_len_r;
    logic [9:0]  frame_lines_r;

    logic        timeout;
    logic        meas_bad;
    logic [9:0]  lines_total;
    logic        frame_good;

    assign h_edge   = link.hsync_in & ~hsync_q;
    assign v_edge   = link.vsync_in & ~vsync_q;
    assign timeout  = (hcnt == TIMEOUT_CLKS);
    assign meas_bad = h_edge & hsync_seen & ((hcnt + 11'd1) != LINE_CLKS);

    // An h_edge coinciding with v_edge still belongs to the frame that is ending.
    assign lines_total = line_cnt + (h_edge ? 10'd1 : 10'd0);
    assign frame_good  = (lines_total == FRAME_LEN) && !(line_bad || meas_bad);

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        err_next   = 1'b0;
        if (timeout) begin
            state_next = SEARCH;
            good_next  = '0;
            err_next   = (state == LOCKED);
        end else if (v_edge) begin
            case (state)
                SEARCH: begin
                    state_next = VERIFY;
                    good_next  = '0;
                end
                VERIFY: begin
                    if (frame_good) begin
                        good_next = good_cnt + 8'd1;
                        if (good_cnt + 8'd1 == LOCK_N) state_next = LOCKED;
                    end else begin
                        good_next = '0;
                    end
                end
                LOCKED: begin
                    if (!frame_good) begin
                        state_next = SEARCH;
                        good_next  = '0;
                        err_next   = 1'b1;
                    end
                end
                default: begin
                    state_next = SEARCH;
                    good_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SEARCH;
            good_cnt      <= '0;
            timing_err_r  <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hcnt          <= '0;
            hsync_seen    <= 1'b0;
            line_bad      <= 1'b0;
            line_cnt      <= '0;
            v_pend        <= 1'b0;
            hpos_r        <= '0;
            vpos_r        <= '0;
            line_len_r    <= '0;
            frame_lines_r <= '0;
        end else begin
            state        <= state_next;
            good_cnt     <= good_next;
            timing_err_r <= err_next;
            hsync_q      <= link.hsync_in;
            vsync_q      <= link.vsync_in;

            if (h_edge)           hcnt <= '0;
            else if (hcnt != '1)  hcnt <= hcnt + 11'd1;

            if (h_edge) begin
                if (hsync_seen) line_len_r <= hcnt + 11'd1;
                hsync_seen <= 1'b1;
            end
            if (timeout) hsync_seen <= 1'b0;

            if (v_edge)        line_bad <= 1'b0;
            else if (meas_bad) line_bad <= 1'b1;

            if (v_edge) begin
                frame_lines_r <= lines_total;
                line_cnt      <= '0;
            end else if (h_edge && line_cnt != '1) begin
                line_cnt <= line_cnt + 10'd1;
            end

            if (h_edge) begin
                hpos_r <= H_LOAD;
            end else if (hpos_r == H_LAST) begin
                hpos_r <= '0;
                if (v_pend) begin
                    vpos_r <= V_LOAD;
                    v_pend <= 1'b0;
                end else if (vpos_r == V_LAST) begin
                    vpos_r <= '0;
                end else begin
                    vpos_r <= vpos_r + 10'd1;
                end
            end else begin
                hpos_r <= hpos_r + 10'd1;
            end
            // Placed after the wrap so a v_edge on a wrap cycle is not lost.
            if (v_edge) v_pend <= 1'b1;
        end
    end

    assign link.hpos        = hpos_r;
    assign link.vpos        = vpos_r;
    assign link.locked      = (state == LOCKED);
    assign link.display_on  = (state == LOCKED) && (hpos_r < H_VIS) && (vpos_r < V_VIS);
    assign link.timing_err  = timing_err_r;
    assign link.line_len    = line_len_r;
    assign link.frame_lines = frame_lines_r;
endmodule

// File: tb/tb_vga_sync_analyzer.sv
// Directed bench for vga_sync_analyzer on a reduced 20x15 timing:
// hsync at hpos 16..17, vsync on lines 11..12, hpos/vpos recovered 2 pixels ahead.
module tb_vga_sync_analyzer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_sync_analyzer_if link();

    vga_sync_analyzer #(
        .H_DISPLAY  (16),
        .H_MAX      (19),
        .V_DISPLAY  (10),
        .V_MAX      (14),
        .H_EDGE_POS (18),
        .V_EDGE_POS (12),
        .LOCK_FRAMES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .link (link.slave)
    );

    int checks = 0;
    int errors = 0;
    int gh, gv, glen, vs_line;
    bit hs_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive the generator position, clock once, sample 1 time unit after the edge.
    task automatic step();
        link.hsync_in = hs_en && (gh >= 16) && (gh <= 17);
        link.vsync_in = (gv >= vs_line) && (gv <= vs_line + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic advance();
        gh++;
        if (gh >= glen) begin
            gh = 0;
            gv = (gv == 14) ? 0 : gv + 1;
        end
    endtask

    task automatic tick();
        step();
        advance();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_hpos"},        32'(link.hpos),        0);
        check({tag, "_vpos"},        32'(link.vpos),        0);
        check({tag, "_locked"},      32'(link.locked),      0);
        check({tag, "_timing_err"},  32'(link.timing_err),  0);
        check({tag, "_line_len"},    32'(link.line_len),    0);
        check({tag, "_frame_lines"}, 32'(link.frame_lines), 0);
        check({tag, "_display_on"},  32'(link.display_on),  0);
    endtask

    task automatic gen_restart();
        gh = 0; gv = 0; glen = 20; vs_line = 11; hs_en = 1'b1;
        link.hsync_in = 1'b0;
        link.vsync_in = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int disp;
        reset = 1'b1;
        gen_restart();
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        reset = 1'b0;

        // Lock on the 3rd vsync edge (generator index 820)
        run(820);
        check("t1_prelock", 32'(link.locked), 0);
        tick();
        check("t1_locked",      32'(link.locked),      1);
        check("t1_line_len",    32'(link.line_len),    20);
        check("t1_frame_lines", 32'(link.frame_lines), 15);
        check("t1_timing_err",  32'(link.timing_err),  0);

        // One full frame of recovered position against the generator
        disp = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            p = gv * 20 + gh + 2;
            if (p >= 300) p -= 300;
            check("t2_hpos", 32'(link.hpos), p % 20);
            check("t2_vpos", 32'(link.vpos), p / 20);
            if (link.display_on) disp++;
            advance();
        end
        check("t2_display_cnt", disp, 160);
        check("t2_locked", 32'(link.locked), 1);

        // Short frame: vsync moved to line 5 for one frame
        run(79);
        vs_line = 5;
        run(100);
        check("t3_pre_locked", 32'(link.locked),     1);
        check("t3_pre_err",    32'(link.timing_err), 0);
        tick();
        check("t3_err_pulse",   32'(link.timing_err),  1);
        check("t3_unlocked",    32'(link.locked),      0);
        check("t3_frame_lines", 32'(link.frame_lines), 9);
        tick();
        check("t3_err_end", 32'(link.timing_err), 0);
        run(38);
        vs_line = 11;
        run(680);
        check("t3_not_relocked", 32'(link.locked), 0);
        tick();
        check("t3_relocked",     32'(link.locked),      1);
        check("t3_frame_lines2", 32'(link.frame_lines), 15);

        // One 21-clock line
        run(39);
        glen = 21;
        run(21);
        glen = 20;
        run(16);
        tick();
        check("t4_line_len", 32'(link.line_len), 21);
        run(3);
        run(220);
        check("t4_pre_locked", 32'(link.locked),     1);
        check("t4_pre_err",    32'(link.timing_err), 0);
        tick();
        check("t4_err_pulse",   32'(link.timing_err),  1);
        check("t4_unlocked",    32'(link.locked),      0);
        check("t4_frame_lines", 32'(link.frame_lines), 15);
        tick();
        check("t4_err_end", 32'(link.timing_err), 0);

        // Relock, then lose hsync; last edge was 41 clocks before the timeout clock
        run(898);
        tick();
        check("t5_locked", 32'(link.locked), 1);
        hs_en = 1'b0;
        run(36);
        check("t5_pre_timeout", 32'(link.locked),     1);
        check("t5_pre_err",     32'(link.timing_err), 0);
        tick();
        check("t5_unlocked",  32'(link.locked),     0);
        check("t5_err_pulse", 32'(link.timing_err), 1);
        tick();
        check("t5_err_end", 32'(link.timing_err), 0);
        run(2100);
        check("t5_hcnt_sat", 32'(dut.hcnt),     2047);
        check("t5_still_off", 32'(link.locked), 0);

        // Reset mid-line while locked
        reset = 1'b1;
        gen_restart();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run(820);
        tick();
        check("t6_locked", 32'(link.locked), 1);
        run(44);
        reset = 1'b1;
        tick();
        check_reset("t6_rst");
        reset = 1'b0;
        run(854);
        check("t6_not_relocked", 32'(link.locked), 0);
        tick();
        check("t6_relocked", 32'(link.locked), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
